// File: rtl/lcd_ram_arb.sv
// Arbiter sharing one single-port frame RAM between capture writes, display reads
// and host accesses. Grants are decided at each edge and issued the next cycle.
module lcd_ram_arb #(
  parameter logic [12:0] RAM_TOP     = 13'h17bf,
  parameter int unsigned HST_MAXWAIT = 8
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        cap_wrreq,
  output logic        cap_wrack,
  input  logic [12:0] cap_waddr,
  input  logic [7:0]  cap_wdata,
  input  logic        dsp_rdreq,
  output logic        dsp_rdack,
  input  logic [12:0] dsp_raddr,
  output logic [7:0]  dsp_rdata,
  output logic        dsp_rvalid,
  input  logic        hst_req,
  input  logic        hst_we,
  input  logic [12:0] hst_addr,
  input  logic [7:0]  hst_wdata,
  output logic        hst_ack,
  output logic [7:0]  hst_rdata,
  output logic        hst_rvalid,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CAP,
    OWN_DSP,
    OWN_HST
  } owner_e;

  // Read tag travelling alongside an access until its data comes back.
  typedef struct packed {
    logic dsp;
    logic hst;
    logic oor;
  } rd_tag_t;

  owner_e      owner_q, owner_d;
  logic [3:0]  wait_q, wait_d;
  logic        cap_el, dsp_el, hst_el, hst_urgent;
  logic        sel_we, sel_oor;
  logic [12:0] sel_addr;
  logic [7:0]  sel_wdata;
  rd_tag_t     rd1_d, rd1_q, rd2_q;
  logic        ram_cs_q, ram_we_q;
  logic [12:0] ram_addr_q;
  logic [7:0]  ram_wdata_q;
  logic        dsp_rvalid_q, hst_rvalid_q;
  logic [7:0]  dsp_rdata_q, hst_rdata_q;

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    cap_el     = cap_wrreq && (owner_q != OWN_CAP);
    dsp_el     = dsp_rdreq && (owner_q != OWN_DSP);
    hst_el     = hst_req   && (owner_q != OWN_HST);
    hst_urgent = hst_el && (32'(wait_q) >= HST_MAXWAIT);

    owner_d = OWN_IDLE;
    if (cap_el)          owner_d = OWN_CAP;
    else if (hst_urgent) owner_d = OWN_HST;
    else if (dsp_el)     owner_d = OWN_DSP;
    else if (hst_el)     owner_d = OWN_HST;

    wait_d = wait_q;
    if (!hst_req || (owner_q == OWN_HST)) wait_d = 4'd0;
    else if ((owner_d != OWN_HST) && (wait_q != 4'hf)) wait_d = wait_q + 4'd1;

    sel_we    = 1'b0;
    sel_addr  = ram_addr_q;
    sel_wdata = ram_wdata_q;
    case (owner_d)
      OWN_CAP: begin
        sel_we    = 1'b1;
        sel_addr  = cap_waddr;
        sel_wdata = cap_wdata;
      end
      OWN_DSP: sel_addr = dsp_raddr;
      OWN_HST: begin
        sel_we    = hst_we;
        sel_addr  = hst_addr;
        sel_wdata = hst_wdata;
      end
      default: ;
    endcase
    sel_oor = (owner_d != OWN_IDLE) && (sel_addr > RAM_TOP);

    rd1_d.dsp = (owner_d == OWN_DSP);
    rd1_d.hst = (owner_d == OWN_HST) && !hst_we;
    rd1_d.oor = sel_oor;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      owner_q      <= OWN_IDLE;
      wait_q       <= 4'd0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      ram_cs_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 13'h0000;
      ram_wdata_q  <= 8'h00;
      dsp_rvalid_q <= 1'b0;
      hst_rvalid_q <= 1'b0;
      dsp_rdata_q  <= 8'h00;
      hst_rdata_q  <= 8'h00;
    end else begin
      owner_q      <= owner_d;
      wait_q       <= wait_d;
      ram_cs_q     <= (owner_d != OWN_IDLE) && !sel_oor;
      ram_we_q     <= sel_we && !sel_oor;
      ram_addr_q   <= sel_addr;
      ram_wdata_q  <= sel_wdata;
      rd1_q        <= rd1_d;
      rd2_q        <= rd1_q;
      dsp_rvalid_q <= rd2_q.dsp;
      hst_rvalid_q <= rd2_q.hst;
      // Out-of-range reads never touched the RAM, so they return zero.
      if (rd2_q.dsp) dsp_rdata_q <= rd2_q.oor ? 8'h00 : ram_rdata;
      if (rd2_q.hst) hst_rdata_q <= rd2_q.oor ? 8'h00 : ram_rdata;
    end
  end

  assign cap_wrack  = (owner_q == OWN_CAP);
  assign dsp_rdack  = (owner_q == OWN_DSP);
  assign hst_ack    = (owner_q == OWN_HST);
  assign ram_cs     = ram_cs_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign dsp_rdata  = dsp_rdata_q;
  assign dsp_rvalid = dsp_rvalid_q;
  assign hst_rdata  = hst_rdata_q;
  assign hst_rvalid = hst_rvalid_q;

endmodule

// File: tb/tb_lcd_ram_arb.sv
// Directed bench for lcd_ram_arb with a behavioural synchronous RAM attached.
module tb_lcd_ram_arb;

  logic        clk, rst_x;
  logic        cap_wrreq, cap_wrack;
  logic [12:0] cap_waddr;
  logic [7:0]  cap_wdata;
  logic        dsp_rdreq, dsp_rdack;
  logic [12:0] dsp_raddr;
  logic [7:0]  dsp_rdata;
  logic        dsp_rvalid;
  logic        hst_req, hst_we, hst_ack, hst_rvalid;
  logic [12:0] hst_addr;
  logic [7:0]  hst_wdata, hst_rdata;
  logic        ram_cs, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  lcd_ram_arb dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .cap_wrreq  (cap_wrreq),
    .cap_wrack  (cap_wrack),
    .cap_waddr  (cap_waddr),
    .cap_wdata  (cap_wdata),
    .dsp_rdreq  (dsp_rdreq),
    .dsp_rdack  (dsp_rdack),
    .dsp_raddr  (dsp_raddr),
    .dsp_rdata  (dsp_rdata),
    .dsp_rvalid (dsp_rvalid),
    .hst_req    (hst_req),
    .hst_we     (hst_we),
    .hst_addr   (hst_addr),
    .hst_wdata  (hst_wdata),
    .hst_ack    (hst_ack),
    .hst_rdata  (hst_rdata),
    .hst_rvalid (hst_rvalid),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the strobe.
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_cs && ram_we)  mem[ram_addr] <= ram_wdata;
    if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input bit ok);
    total++;
    if (ok) passed++;
    else begin
      failed++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  got;
    rst_x = 1'b0;
    cap_wrreq = 1'b0; cap_waddr = '0; cap_wdata = '0;
    dsp_rdreq = 1'b0; dsp_raddr = '0;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_wdata = '0;
    for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    mem[13'h0500] <= 8'h3C;
    mem[13'h17bf] <= 8'hC3;
    ram_rdata <= 8'h00;

    #12;
    check("rst_cap_wrack", cap_wrack === 1'b0);
    check("rst_dsp_rdack", dsp_rdack === 1'b0);
    check("rst_hst_ack", hst_ack === 1'b0);
    check("rst_dsp_rvalid", dsp_rvalid === 1'b0);
    check("rst_hst_rvalid", hst_rvalid === 1'b0);
    check("rst_ram_cs", ram_cs === 1'b0);
    check("rst_ram_we", ram_we === 1'b0);
    check("rst_ram_addr", ram_addr === 13'h0000);
    check("rst_ram_wdata", ram_wdata === 8'h00);
    check("rst_dsp_rdata", dsp_rdata === 8'h00);
    check("rst_hst_rdata", hst_rdata === 8'h00);
    #1 rst_x = 1'b1;
    step();

    // Single capture write; request held one edge past the ack.
    cap_wrreq = 1'b1; cap_waddr = 13'h0010; cap_wdata = 8'hA5;
    step();
    check("cap_ack", cap_wrack === 1'b1);
    check("cap_cs", ram_cs === 1'b1);
    check("cap_we", ram_we === 1'b1);
    check("cap_addr", ram_addr === 13'h0010);
    check("cap_wdata", ram_wdata === 8'hA5);
    step();
    check("cap_no_reack", cap_wrack === 1'b0);
    check("cap_no_rewrite", ram_cs === 1'b0);
    check("idle_we", ram_we === 1'b0);
    check("idle_addr_hold", ram_addr === 13'h0010);
    cap_wrreq = 1'b0;
    step();
    check("idle_cs", ram_cs === 1'b0);

    // Display read latency.
    dsp_rdreq = 1'b1; dsp_raddr = 13'h0500;
    step();
    check("dsp_ack", dsp_rdack === 1'b1);
    check("dsp_cs", ram_cs === 1'b1);
    check("dsp_we", ram_we === 1'b0);
    check("dsp_addr", ram_addr === 13'h0500);
    dsp_rdreq = 1'b0;
    step();
    check("dsp_ack_once", dsp_rdack === 1'b0);
    check("dsp_rvalid_n1", dsp_rvalid === 1'b0);
    step();
    check("dsp_rvalid_n2", dsp_rvalid === 1'b1);
    check("dsp_rdata_n2", dsp_rdata === 8'h3C);
    step();
    check("dsp_rvalid_n3", dsp_rvalid === 1'b0);
    check("dsp_rdata_hold", dsp_rdata === 8'h3C);

    // All three at once: CAP, DSP, HST in consecutive cycles.
    cap_wrreq = 1'b1; cap_waddr = 13'h0020; cap_wdata = 8'h5A;
    dsp_rdreq = 1'b1; dsp_raddr = 13'h0010;
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 13'h0030; hst_wdata = 8'h77;
    step();
    check("all_c1_cap", cap_wrack === 1'b1);
    check("all_c1_dsp", dsp_rdack === 1'b0);
    check("all_c1_hst", hst_ack === 1'b0);
    check("all_c1_addr", ram_addr === 13'h0020);
    cap_wrreq = 1'b0;
    step();
    check("all_c2_cap", cap_wrack === 1'b0);
    check("all_c2_dsp", dsp_rdack === 1'b1);
    check("all_c2_hst", hst_ack === 1'b0);
    check("all_c2_addr", ram_addr === 13'h0010);
    dsp_rdreq = 1'b0;
    step();
    check("all_c3_cap", cap_wrack === 1'b0);
    check("all_c3_dsp", dsp_rdack === 1'b0);
    check("all_c3_hst", hst_ack === 1'b1);
    check("all_c3_we", ram_we === 1'b1);
    check("all_c3_addr", ram_addr === 13'h0030);
    check("all_c3_wdata", ram_wdata === 8'h77);
    hst_req = 1'b0;
    step();
    check("all_c4_hst", hst_ack === 1'b0);
    check("all_c4_dsp", dsp_rdack === 1'b0);
    check("all_c4_rvalid", dsp_rvalid === 1'b1);
    check("all_c4_rdata", dsp_rdata === 8'hA5);

    // Back-to-back reads by different owners.
    dsp_rdreq = 1'b1; dsp_raddr = 13'h0020;
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 13'h0030;
    step();
    check("pipe_dsp_ack", dsp_rdack === 1'b1);
    dsp_rdreq = 1'b0;
    step();
    check("pipe_hst_ack", hst_ack === 1'b1);
    check("pipe_hst_addr", ram_addr === 13'h0030);
    hst_req = 1'b0;
    step();
    check("pipe_dsp_rvalid", dsp_rvalid === 1'b1);
    check("pipe_dsp_rdata", dsp_rdata === 8'h5A);
    check("pipe_hst_rvalid_early", hst_rvalid === 1'b0);
    step();
    check("pipe_hst_rvalid", hst_rvalid === 1'b1);
    check("pipe_hst_rdata", hst_rdata === 8'h77);
    check("pipe_dsp_rvalid_once", dsp_rvalid === 1'b0);

    // Out-of-range host write then read.
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 13'h17c0; hst_wdata = 8'hFF;
    step();
    check("oor_wr_ack", hst_ack === 1'b1);
    check("oor_wr_cs", ram_cs === 1'b0);
    hst_req = 1'b0;
    step();
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 13'h1800;
    step();
    check("oor_rd_ack", hst_ack === 1'b1);
    check("oor_rd_cs", ram_cs === 1'b0);
    hst_req = 1'b0;
    step();
    step();
    check("oor_rd_rvalid", hst_rvalid === 1'b1);
    check("oor_rd_rdata", hst_rdata === 8'h00);

    // Highest valid address is a real access.
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 13'h17bf;
    step();
    check("top_ack", hst_ack === 1'b1);
    check("top_cs", ram_cs === 1'b1);
    hst_req = 1'b0;
    step();
    step();
    check("top_rvalid", hst_rvalid === 1'b1);
    check("top_rdata", hst_rdata === 8'hC3);

    // Host request withdrawn before it was served.
    cap_wrreq = 1'b1; cap_waddr = 13'h0050; cap_wdata = 8'h99;
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 13'h0060; hst_wdata = 8'h66;
    step();
    check("drop_cap_ack", cap_wrack === 1'b1);
    check("drop_hst_wait", hst_ack === 1'b0);
    cap_wrreq = 1'b0; hst_req = 1'b0;
    step();
    check("drop_no_ack", hst_ack === 1'b0);
    check("drop_no_cs", ram_cs === 1'b0);
    step();
    check("drop_no_ack2", hst_ack === 1'b0);

    // Host starvation limit while capture and display alternate.
    cap_wrreq = 1'b1; cap_waddr = 13'h0040; cap_wdata = 8'h11;
    dsp_rdreq = 1'b1; dsp_raddr = 13'h0020;
    step();
    step();
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 13'h0020;
    n = 0; got = 1'b0;
    while (!got && n < 14) begin
      step();
      n++;
      if (hst_ack) got = 1'b1;
    end
    check("starve_acked", got === 1'b1);
    check("starve_latency", n <= 10);
    cap_wrreq = 1'b0; dsp_rdreq = 1'b0; hst_req = 1'b0;
    step();
    step();
    step();

    // Reset in the middle of a display access.
    dsp_rdreq = 1'b1; dsp_raddr = 13'h0500;
    step();
    check("rstacc_ack", dsp_rdack === 1'b1);
    dsp_rdreq = 1'b0;
    #2 rst_x = 1'b0;
    #1;
    check("rstacc_dsp_ack", dsp_rdack === 1'b0);
    check("rstacc_cs", ram_cs === 1'b0);
    check("rstacc_addr", ram_addr === 13'h0000);
    check("rstacc_dsp_rdata", dsp_rdata === 8'h00);
    check("rstacc_hst_rdata", hst_rdata === 8'h00);
    @(posedge clk);
    #3 rst_x = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstacc_no_rvalid", dsp_rvalid === 1'b0);
      check("rstacc_no_ack", dsp_rdack === 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcd_ram_arb.md
LCD_RAM_ARB -- requirements
Module: lcd_ram_arb

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
 clk  in  1  clock
 rst_x  in  1  reset, asynchronous, active-low
 cap_wrreq  in  1  capture write request, held until cap_wrack
 cap_wrack  out  1  capture write ack, one-cycle pulse
 cap_waddr  in  13  capture write address
 cap_wdata  in  8  capture write data
 dsp_rdreq  in  1  display read request, held until dsp_rdack
 dsp_rdack  out  1  display read ack, one-cycle pulse
 dsp_raddr  in  13  display read address
 dsp_rdata  out  8  display read data
 dsp_rvalid  out  1  dsp_rdata valid, one-cycle pulse
 hst_req  in  1  host request, held until hst_ack
 hst_we  in  1  host write (1) / read (0)
 hst_addr  in  13  host address
 hst_wdata  in  8  host write data
 hst_ack  out  1  host ack, one-cycle pulse
 hst_rdata  out  8  host read data
 hst_rvalid  out  1  hst_rdata valid, one-cycle pulse
 ram_cs  out  1  RAM access strobe
 ram_we  out  1  RAM write enable
 ram_addr  out  13  RAM address
 ram_wdata  out  8  RAM write data
 ram_rdata  in  8  RAM read data, valid the cycle after ram_cs with ram_we=0
REQ-002 SHALL have parameters: RAM_TOP, default 13'h17bf, highest valid address; HST_MAXWAIT, default 8, host starvation limit in cycles.

Function
REQ-003 SHALL grant at most one requester per cycle; owner states IDLE, CAP, DSP, HST held in a registered owner field.
REQ-004 Decision at each clk edge from sampled requests; granted access issued in the following cycle: ram_cs, ram_we, ram_addr, ram_wdata, and the owner's ack all asserted in that same cycle (min latency req -> ack = 1 cycle).
REQ-005 Priority: CAP > DSP > HST, except HST SHALL win over DSP (never over CAP) when host wait counter >= HST_MAXWAIT.
REQ-006 Host wait counter (4-bit) SHALL increment each cycle hst_req=1 and host not granted, saturate at 15, clear on hst_ack or hst_req=0.
REQ-007 The owner of cycle N SHALL be ineligible in the decision at the end of cycle N (requester drops req one edge after ack); eligible again from the next decision.
REQ-008 IDLE: ram_cs=0, ram_we=0, all acks 0; ram_addr/ram_wdata hold last value.
REQ-009 CAP access: ram_we=1, ram_addr=cap_waddr, ram_wdata=cap_wdata.
REQ-010 DSP access: ram_we=0, ram_addr=dsp_raddr; ram_rdata registered into dsp_rdata at end of access+1, dsp_rvalid=1 in access+2 for one cycle; dsp_rdata holds until next update.
REQ-011 HST access: ram_we=hst_we; reads return data exactly as REQ-010 on hst_rdata/hst_rvalid.
REQ-012 Address > RAM_TOP from any requester SHALL be acked normally with ram_cs=0; such reads SHALL return 8'h00 with rvalid at access+2.
REQ-013 Back-to-back reads by different owners SHALL pipeline: one access per cycle, each rvalid routed to its issuing owner in order.
REQ-014 Request deasserted before ack SHALL be dropped without ack or RAM access.

Reset
REQ-015 rst_x low SHALL asynchronously force owner=IDLE, wait counter=0, all acks/rvalids/ram_cs/ram_we=0, ram_addr=13'h0000, ram_wdata/dsp_rdata/hst_rdata=8'h00.
REQ-016 Reset during an access SHALL abandon it; no ack or rvalid for it after rst_x deasserts.

Verification
REQ-017 Single capture: cap_wrreq with addr 13'h0010, data 8'hA5 -> next cycle cap_wrack=1, ram_cs=1, ram_we=1, ram_addr=13'h0010, ram_wdata=8'hA5; no second write.
REQ-018 Simultaneous cap_wrreq, dsp_rdreq, hst_req -> grants CAP, DSP, HST in consecutive cycles; each ack exactly once.
REQ-019 Display read 13'h0500, RAM returns 8'h3C -> dsp_rdack at N, dsp_rvalid=1 and dsp_rdata=8'h3C at N+2.
REQ-020 Host read held while capture+display alternate continuously -> hst_ack within HST_MAXWAIT+2 cycles of hst_req.
REQ-021 Host write to 13'h17c0 -> hst_ack=1, ram_cs=0; host read 13'h1800 -> hst_rvalid with hst_rdata=8'h00.
REQ-022 rst_x low in cycle of DSP access -> no dsp_rvalid afterward; all outputs at REQ-015 values.
